// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath: op codes, ALU stage state encoding, data width.
// Pure declarations; no logic and no timing of its own.
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_PASSB = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOTA  = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: load on start, one iteration per clock, last flags final iteration.
// Result visible on prod_next during the last iteration; MUL_CYCLES iterations after load, no stall.
module alu_mul_iter #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_next,
  output logic               last
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [CW-1:0]      cnt;
  logic               active;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign last      = active && (cnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      active <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (active) begin
      prod   <= prod_next;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      if (last) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU stage feeding the accumulator: 1-cycle logic/add/sub, MUL_CYCLES+1 cycles for MUL.
// start is only accepted while not busy; requests during MUL are dropped, not queued.
module alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             busy,
  output logic             done,
  output logic             load_acc
);

  state_t state, state_nxt;

  logic               cap;
  logic               op_ok;
  logic               op_vld_q;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_last;

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (cap && (op == OP_MUL)),
    .a         (a),
    .b         (b),
    .prod_next (prod_next),
    .last      (mul_last)
  );

  assign cap = start && (state != ST_MUL);

  // Combinational decode of the single-cycle ops; MUL is only flagged valid here.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    op_ok   = 1'b1;
    case (op)
      OP_PASSB: alu_res = b;
      OP_ADD:   {alu_c, alu_res} = {1'b0, a} + {1'b0, b};
      OP_SUB:   {alu_c, alu_res} = {1'b0, a} - {1'b0, b};
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NOTA:  alu_res = ~a;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_MUL:   op_ok = 1'b1;
      default:  op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = (op == OP_MUL) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL:  state_nxt = mul_last ? ST_DONE : ST_MUL;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_MUL);
    done     = (state == ST_DONE);
    load_acc = (state == ST_DONE) && op_vld_q;
  end

  // Illegal ops leave result and flags untouched; MUL writes them on its final iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      op_vld_q <= 1'b0;
    end else if (cap) begin
      op_vld_q <= op_ok;
      if (op_ok && (op != OP_MUL)) begin
        result   <= alu_res;
        carry    <= alu_c;
        zero     <= (alu_res == '0);
        negative <= alu_res[WIDTH-1];
      end
    end else if ((state == ST_MUL) && mul_last) begin
      result   <= prod_next[WIDTH-1:0];
      carry    <= |prod_next[2*WIDTH-1:WIDTH];
      zero     <= (prod_next[WIDTH-1:0] == '0);
      negative <= prod_next[WIDTH-1];
    end
  end

endmodule
